// File: rtl/gauss_filter_ctrl.sv
// rtl/gauss_filter_ctrl.sv - tap loader and bit upsampler in front of gauss_filter
module gauss_filter_ctrl #(
    parameter int GAUSS_FILTER_BIT_WIDTH = 16,
    parameter int NUM_TAP_GAUSS_FILTER   = 17,
    parameter int SAMPLE_PER_SYMBOL      = 8,
    parameter int CLK_PER_SAMPLE         = 2,
    parameter int NUM_PAD_SAMPLE         = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              tap_wr_en,
    input  logic [3:0]                        tap_wr_addr,
    input  logic [GAUSS_FILTER_BIT_WIDTH-1:0] tap_wr_data,
    input  logic                              start,
    input  logic [11:0]                       num_bit,
    input  logic                              info_bit,
    input  logic                              info_bit_valid,
    output logic                              info_bit_ready,
    output logic [3:0]                        tap_index,
    output logic [GAUSS_FILTER_BIT_WIDTH-1:0] tap_value,
    output logic                              bit_upsample,
    output logic                              bit_upsample_valid,
    output logic                              bit_upsample_valid_last,
    output logic                              busy,
    output logic                              done,
    output logic                              underrun
);
    localparam int NUM_HALF = (NUM_TAP_GAUSS_FILTER + 1) / 2;
    localparam int PW = $clog2(CLK_PER_SAMPLE + 1);
    localparam int SW = $clog2(SAMPLE_PER_SYMBOL + 1);
    localparam int DW = $clog2(NUM_PAD_SAMPLE + 2);
    localparam logic [PW-1:0] PH_LAST   = PW'(CLK_PER_SAMPLE - 1);
    localparam logic [SW-1:0] SMP_LAST  = SW'(SAMPLE_PER_SYMBOL - 1);
    localparam logic [DW-1:0] PAD_LAST  = DW'(NUM_PAD_SAMPLE - 1);
    localparam logic [3:0]    HALF_LAST = 4'(NUM_HALF - 1);
    localparam logic          NO_PAD    = (NUM_PAD_SAMPLE == 0);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_TAP, S_FEED, S_FLUSH, S_DONE} state_t;
    localparam state_t AFTER_DATA = NO_PAD ? S_DONE : S_FLUSH;

    state_t                            r_state;
    logic [GAUSS_FILTER_BIT_WIDTH-1:0] r_shadow [NUM_HALF];
    logic [11:0]                       r_num_bit;
    logic [11:0]                       r_fetched;
    logic [11:0]                       r_consumed;
    logic                              r_buf;
    logic                              r_buf_full;
    logic                              r_cur_bit;
    logic [SW-1:0]                     r_sample_cnt;
    logic [PW-1:0]                     r_phase;
    logic [DW-1:0]                     r_pad_cnt;
    logic [3:0]                        r_load_k;
    logic [3:0]                        r_tap_index;
    logic [GAUSS_FILTER_BIT_WIDTH-1:0] r_tap_value;
    logic                              r_upsample;
    logic                              r_valid;
    logic                              r_last;
    logic                              r_busy;
    logic                              r_done;
    logic                              r_underrun;

    logic        w_ready;
    logic        w_hs;
    logic        w_strobe;
    logic        w_new_sym;
    logic        w_emit_bit;
    logic        w_final_bit;
    logic        w_tap_we;
    logic [11:0] w_cons_now;

    assign w_ready   = (r_state == S_FEED) && !r_buf_full && (r_fetched < r_num_bit);
    assign w_hs      = w_ready && info_bit_valid;
    assign w_strobe  = (r_phase == '0);
    assign w_new_sym = (r_sample_cnt == '0);
    assign w_tap_we  = tap_wr_en && !r_busy && (tap_wr_addr < 4'(NUM_HALF));

    // A bit arriving on the same cycle as a symbol-start strobe bypasses the buffer.
    always_comb begin
        w_emit_bit  = r_cur_bit;
        w_cons_now  = r_consumed;
        if (w_new_sym) begin
            w_emit_bit = r_buf_full ? r_buf : info_bit;
            w_cons_now = r_consumed + 12'd1;
        end
        w_final_bit = (w_cons_now == r_num_bit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_HALF; i++) r_shadow[i] <= '0;
        end else if (w_tap_we) begin
            r_shadow[tap_wr_addr] <= tap_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_num_bit    <= '0;
            r_fetched    <= '0;
            r_consumed   <= '0;
            r_buf        <= 1'b0;
            r_buf_full   <= 1'b0;
            r_cur_bit    <= 1'b0;
            r_sample_cnt <= '0;
            r_phase      <= '0;
            r_pad_cnt    <= '0;
            r_load_k     <= '0;
            r_tap_index  <= '0;
            r_tap_value  <= '0;
            r_upsample   <= 1'b0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
            if (w_hs) r_fetched <= r_fetched + 12'd1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_bit    <= num_bit;
                        r_underrun   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_fetched    <= '0;
                        r_consumed   <= '0;
                        r_buf_full   <= 1'b0;
                        r_sample_cnt <= '0;
                        r_pad_cnt    <= '0;
                        r_load_k     <= '0;
                        r_tap_index  <= '0;
                        r_tap_value  <= r_shadow[0];
                        r_state      <= S_LOAD_TAP;
                    end
                end
                S_LOAD_TAP: begin
                    if (r_load_k == HALF_LAST) begin
                        r_phase <= '0;
                        r_state <= (r_num_bit == 12'd0) ? AFTER_DATA : S_FEED;
                    end else begin
                        r_load_k    <= r_load_k + 4'd1;
                        r_tap_index <= r_load_k + 4'd1;
                        r_tap_value <= r_shadow[r_load_k + 4'd1];
                    end
                end
                S_FEED: begin
                    if (w_hs && !(w_strobe && w_new_sym)) begin
                        r_buf      <= info_bit;
                        r_buf_full <= 1'b1;
                    end
                    if (w_strobe) begin
                        if (w_new_sym && !r_buf_full && !w_hs) begin
                            r_underrun <= 1'b1;
                        end else begin
                            if (w_new_sym) begin
                                r_cur_bit  <= w_emit_bit;
                                r_buf_full <= 1'b0;
                                r_consumed <= w_cons_now;
                            end
                            r_valid    <= 1'b1;
                            r_upsample <= w_emit_bit;
                            if (r_sample_cnt == SMP_LAST) begin
                                r_sample_cnt <= '0;
                                if (w_final_bit) begin
                                    r_last  <= NO_PAD;
                                    r_state <= AFTER_DATA;
                                end
                            end else begin
                                r_sample_cnt <= r_sample_cnt + 1'b1;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_strobe) begin
                        r_valid    <= 1'b1;
                        r_upsample <= 1'b0;
                        if (r_pad_cnt == PAD_LAST) begin
                            r_last  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_pad_cnt <= r_pad_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign info_bit_ready          = w_ready;
    assign tap_index               = r_tap_index;
    assign tap_value               = r_tap_value;
    assign bit_upsample            = r_upsample;
    assign bit_upsample_valid      = r_valid;
    assign bit_upsample_valid_last = r_last;
    assign busy                    = r_busy;
    assign done                    = r_done;
    assign underrun                = r_underrun;
endmodule

// File: tb/tb_gauss_filter_ctrl.sv
// tb/tb_gauss_filter_ctrl.sv - self-checking bench for gauss_filter_ctrl
module tb_gauss_filter_ctrl;
    localparam int SPS = 8;
    localparam int CPS = 2;
    localparam int PAD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tap_wr_en = 1'b0;
    logic [3:0]  tap_wr_addr = '0;
    logic [15:0] tap_wr_data = '0;
    logic        start = 1'b0;
    logic        start0 = 1'b0;
    logic [11:0] num_bit = '0;
    logic        info_bit = 1'b0;
    logic        info_bit_valid = 1'b0;

    logic        info_bit_ready, bit_upsample, bit_upsample_valid, bit_upsample_valid_last;
    logic        busy, done, underrun;
    logic [3:0]  tap_index;
    logic [15:0] tap_value;

    logic        ready0, ups0, valid0, last0, busy0, done0, underrun0;
    logic [3:0]  tap_index0;
    logic [15:0] tap_value0;

    gauss_filter_ctrl dut (
        .clk(clk), .rst(rst), .tap_wr_en(tap_wr_en), .tap_wr_addr(tap_wr_addr),
        .tap_wr_data(tap_wr_data), .start(start), .num_bit(num_bit), .info_bit(info_bit),
        .info_bit_valid(info_bit_valid), .info_bit_ready(info_bit_ready),
        .tap_index(tap_index), .tap_value(tap_value), .bit_upsample(bit_upsample),
        .bit_upsample_valid(bit_upsample_valid), .bit_upsample_valid_last(bit_upsample_valid_last),
        .busy(busy), .done(done), .underrun(underrun)
    );

    gauss_filter_ctrl #(.NUM_PAD_SAMPLE(0)) dut0 (
        .clk(clk), .rst(rst), .tap_wr_en(tap_wr_en), .tap_wr_addr(tap_wr_addr),
        .tap_wr_data(tap_wr_data), .start(start0), .num_bit(num_bit), .info_bit(info_bit),
        .info_bit_valid(info_bit_valid), .info_bit_ready(ready0),
        .tap_index(tap_index0), .tap_value(tap_value0), .bit_upsample(ups0),
        .bit_upsample_valid(valid0), .bit_upsample_valid_last(last0),
        .busy(busy0), .done(done0), .underrun(underrun0)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit b;
        bit last;
    } smp_t;

    smp_t exp_q[$];
    bit   src_q[$];
    bit   bits_a[$] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit   bits_none[$];
    int   exp_tap[9];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   popped = 0;
    int   stall_at = -1;
    int   stall_left = 0;
    bit   hs_flag = 1'b0;
    bit   strict = 1'b1;
    int   n_valid = 0;
    int   n_ones = 0;
    int   prev_cyc = -1;
    int   last_cyc = -1;
    int   max_gap = 0;

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bit source: hs_flag records a handshake that will complete at the coming posedge.
    initial forever begin
        @(negedge clk);
        if (hs_flag && src_q.size() > 0) begin
            void'(src_q.pop_front());
            popped++;
        end
        if (src_q.size() > 0 && !(popped == stall_at && stall_left > 0)) begin
            info_bit_valid = 1'b1;
            info_bit       = src_q[0];
        end else begin
            info_bit_valid = 1'b0;
            if (popped == stall_at && stall_left > 0) stall_left--;
        end
        hs_flag = info_bit_ready && info_bit_valid;
    end

    // Scoreboard of the main instance's sample stream.
    initial forever begin
        @(negedge clk);
        if (bit_upsample_valid) begin
            n_valid++;
            if (bit_upsample) n_ones++;
            if (exp_q.size() == 0) begin
                check_eq("extra_valid", 1, 0);
            end else begin
                smp_t e;
                e = exp_q.pop_front();
                check_eq("sample_bit", int'(bit_upsample), int'(e.b));
                check_eq("sample_last", int'(bit_upsample_valid_last), int'(e.last));
                if (e.last) last_cyc = cyc;
            end
            if (prev_cyc >= 0) begin
                if (cyc - prev_cyc > max_gap) max_gap = cyc - prev_cyc;
                if (strict) check_eq("valid_spacing", cyc - prev_cyc, CPS);
            end
            prev_cyc = cyc;
        end else if (bit_upsample_valid_last) begin
            check_eq("last_without_valid", 1, 0);
        end
    end

    task automatic arm(input bit bits[$], input int n, input bit strict_sp);
        smp_t s;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < SPS; k++) begin
                s.b = bits[i];
                s.last = 1'b0;
                exp_q.push_back(s);
            end
        end
        for (int p = 0; p < PAD; p++) begin
            s.b = 1'b0;
            s.last = 1'b0;
            exp_q.push_back(s);
        end
        if (exp_q.size() > 0) begin
            s = exp_q.pop_back();
            s.last = 1'b1;
            exp_q.push_back(s);
        end
        src_q = bits;
        popped = 0;
        n_valid = 0;
        n_ones = 0;
        prev_cyc = -1;
        last_cyc = -1;
        max_gap = 0;
        strict = strict_sp;
    endtask

    task automatic write_tap(input int addr, input int data);
        tap_wr_en = 1'b1;
        tap_wr_addr = 4'(addr);
        tap_wr_data = 16'(data);
        @(negedge clk);
        tap_wr_en = 1'b0;
    endtask

    task automatic run_packet(input bit bits[$], input int n, input int exp_total,
                              input int exp_ones, input bit strict_sp, input int inject_at);
        int t;
        arm(bits, n, strict_sp);
        num_bit = 12'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check_eq($sformatf("tap_index_%0d", k), int'(tap_index), k);
            check_eq($sformatf("tap_value_%0d", k), int'($signed(tap_value)), exp_tap[k]);
            @(negedge clk);
        end
        t = 0;
        while (!done && t < 3000) begin
            if (n == 0) check_eq("ready_num_bit0", int'(info_bit_ready), 0);
            if (t == inject_at) begin
                tap_wr_en = 1'b1;
                tap_wr_addr = 4'd3;
                tap_wr_data = 16'd999;
                start = 1'b1;
                num_bit = 12'd1;
            end else if (t == inject_at + 1) begin
                tap_wr_en = 1'b0;
                start = 1'b0;
                num_bit = 12'(n);
            end
            @(negedge clk);
            t++;
        end
        if (!done) begin
            check_eq("done_timeout", 0, 1);
        end else begin
            check_eq("busy_low_at_done", int'(busy), 0);
            check_eq("done_after_last", cyc - last_cyc, 1);
        end
        check_eq("valid_count", n_valid, exp_total);
        check_eq("ones_count", n_ones, exp_ones);
        check_eq("model_drained", exp_q.size(), 0);
        check_eq("tap_hold_index", int'(tap_index), 8);
        check_eq("tap_hold_value", int'($signed(tap_value)), exp_tap[8]);
        @(negedge clk);
        check_eq("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        int t;
        int taps[9] = '{1, 3, 10, 30, 80, 170, 300, 420, 470};

        repeat (3) @(negedge clk);
        check_eq("rst_valid", int'(bit_upsample_valid), 0);
        check_eq("rst_ready", int'(info_bit_ready), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_underrun", int'(underrun), 0);
        check_eq("rst_tap_index", int'(tap_index), 0);
        check_eq("rst_tap_value", int'(tap_value), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            write_tap(i, taps[i]);
            exp_tap[i] = taps[i];
        end

        run_packet(bits_a, 4, 40, 24, 1'b1, -5);
        check_eq("no_underrun_clean", int'(underrun), 0);

        stall_at = 2;
        stall_left = 40;
        run_packet(bits_a, 4, 40, 24, 1'b0, -5);
        check_eq("underrun_sticky", int'(underrun), 1);
        check_eq("stall_gap_seen", int'(max_gap > CPS), 1);
        stall_at = -1;

        run_packet(bits_none, 0, 8, 0, 1'b1, -5);
        check_eq("underrun_cleared", int'(underrun), 0);

        num_bit = 12'd0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        t = 1;
        while (!done0 && t < 100) begin
            check_eq("nopad_no_valid", int'(valid0), 0);
            @(negedge clk);
            t++;
        end
        check_eq("nopad_done_seen", int'(done0), 1);
        check_eq("nopad_done_after_load", int'(t >= 10), 1);
        check_eq("nopad_no_last", int'(last0), 0);
        check_eq("nopad_busy_low", int'(busy0), 0);

        run_packet(bits_a, 4, 40, 24, 1'b1, 20);
        run_packet(bits_a, 4, 40, 24, 1'b1, -5);

        arm(bits_a, 4, 1'b1);
        num_bit = 12'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", int'(bit_upsample_valid), 0);
        check_eq("mid_rst_ready", int'(info_bit_ready), 0);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_tap_index", int'(tap_index), 0);
        check_eq("mid_rst_tap_value", int'(tap_value), 0);
        exp_q.delete();
        src_q.delete();
        hs_flag = 1'b0;
        for (int i = 0; i < 9; i++) exp_tap[i] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_packet(bits_a, 4, 40, 24, 1'b1, -5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
